// File: rtl/uart_rx_param_if.sv
// Serial receive bundle: line input and baud select in, received word plus status out.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [2:0]           baud_set;
    logic                 Rs232_Rx;
    logic [DATA_BITS-1:0] data_byte;
    logic                 Rx_Done;
    logic                 parity_err;
    logic                 frame_err;
    logic                 busy;

    modport master (
        output baud_set, Rs232_Rx,
        input  data_byte, Rx_Done, parity_err, frame_err, busy
    );

    modport slave (
        input  baud_set, Rs232_Rx,
        output data_byte, Rx_Done, parity_err, frame_err, busy
    );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 16x oversampling, 3-sample majority vote per bit,
// false-start rejection, parity and framing checks.
module uart_rx_param #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input logic           Clk,
    input logic           Rst_n,
    uart_rx_param_if.slave rx
);

    localparam logic [15:0] DIV0_M1 = 16'(CLK_FREQ / (16 * 9600) - 1);
    localparam logic [15:0] DIV1_M1 = 16'(CLK_FREQ / (16 * 19200) - 1);
    localparam logic [15:0] DIV2_M1 = 16'(CLK_FREQ / (16 * 38400) - 1);
    localparam logic [15:0] DIV3_M1 = 16'(CLK_FREQ / (16 * 57600) - 1);
    localparam logic [15:0] DIV4_M1 = 16'(CLK_FREQ / (16 * 115200) - 1);
    localparam logic [3:0]  LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic        LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t               state_q;
    logic                 rx_s1_q, rx_s2_q, rx_prev_q;
    logic [2:0]           baud_q;
    logic [15:0]          div_q;
    logic [3:0]           idx_q;
    logic [3:0]           bit_q;
    logic                 stop_q;
    logic [1:0]           samp_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 fe_acc_q;
    logic                 par_bad_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 done_q;
    logic                 perr_q;
    logic                 ferr_q;

    logic [15:0] div_max;
    logic        tick, at_mid, at_end, vote, stop_bad;

    always_comb begin
        div_max = DIV4_M1;
        case (baud_q)
            3'd0:    div_max = DIV0_M1;
            3'd1:    div_max = DIV1_M1;
            3'd2:    div_max = DIV2_M1;
            3'd3:    div_max = DIV3_M1;
            default: div_max = DIV4_M1;
        endcase
    end

    assign tick     = (state_q != S_IDLE) && (div_q == div_max);
    assign at_mid   = tick && (idx_q == 4'd9);
    assign at_end   = tick && (idx_q == 4'd15);
    // Samples 7 and 8 are held in samp_q; sample 9 is the live synced line.
    assign vote     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s2_q) | (samp_q[1] & rx_s2_q);
    assign stop_bad = fe_acc_q | ~vote;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q   <= S_IDLE;
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            baud_q    <= '0;
            div_q     <= '0;
            idx_q     <= '0;
            bit_q     <= '0;
            stop_q    <= 1'b0;
            samp_q    <= '0;
            shift_q   <= '0;
            fe_acc_q  <= 1'b0;
            par_bad_q <= 1'b0;
            data_q    <= '0;
            done_q    <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_s1_q   <= rx.Rs232_Rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            done_q    <= 1'b0;

            if (state_q == S_IDLE || tick) div_q <= '0;
            else                           div_q <= div_q + 16'd1;

            if (tick) begin
                idx_q <= idx_q + 4'd1;
                if (idx_q == 4'd7) samp_q[0] <= rx_s2_q;
                if (idx_q == 4'd8) samp_q[1] <= rx_s2_q;
            end

            case (state_q)
                S_IDLE: begin
                    idx_q <= '0;
                    if (rx_prev_q && !rx_s2_q) begin
                        state_q   <= S_START;
                        baud_q    <= rx.baud_set;
                        bit_q     <= '0;
                        stop_q    <= 1'b0;
                        fe_acc_q  <= 1'b0;
                        par_bad_q <= 1'b0;
                    end
                end
                S_START: begin
                    if (at_mid && vote) state_q <= S_IDLE;
                    else if (at_end)    state_q <= S_DATA;
                end
                S_DATA: begin
                    if (at_mid) shift_q <= {vote, shift_q[DATA_BITS-1:1]};
                    if (at_end) begin
                        if (bit_q == LAST_BIT) state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
                        else                   bit_q   <= bit_q + 4'd1;
                    end
                end
                S_PARITY: begin
                    if (at_mid) par_bad_q <= (PARITY == 1) ? ~(^shift_q ^ vote) : (^shift_q ^ vote);
                    if (at_end) state_q <= S_STOP;
                end
                S_STOP: begin
                    // Finish at mid-bit of the last stop bit to leave margin for baud skew.
                    if (at_mid) begin
                        if (stop_q == LAST_STOP) begin
                            data_q  <= shift_q;
                            done_q  <= 1'b1;
                            perr_q  <= par_bad_q;
                            ferr_q  <= stop_bad;
                            state_q <= stop_bad ? S_WAIT_HIGH : S_IDLE;
                        end else begin
                            fe_acc_q <= stop_bad;
                        end
                    end
                    if (at_end) stop_q <= 1'b1;
                end
                S_WAIT_HIGH: begin
                    if (rx_s2_q) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rx.data_byte  = data_q;
    assign rx.Rx_Done    = done_q;
    assign rx.parity_err = perr_q;
    assign rx.frame_err  = ferr_q;
    assign rx.busy       = (state_q != S_IDLE);

endmodule
